// File: rtl/dtw_accel_s00_axis_if.sv
// AXI4-Stream beat bundle between the host DMA (master) and the DTW accelerator front end (slave).
interface dtw_accel_s00_axis_if #(
    parameter int unsigned DataWidth = 32
);
    logic                   tvalid;
    logic                   tready;
    logic [DataWidth-1:0]   tdata;
    logic [DataWidth/8-1:0] tstrb;
    logic                   tlast;

    modport master (output tvalid, output tdata, output tstrb, output tlast, input tready);
    modport slave  (input tvalid, input tdata, input tstrb, input tlast, output tready);
endinterface

// File: rtl/dtw_accel_s00_axis.sv
// AXI4-Stream slave front end: tagged FIFO with registered core read port and packet tracking.
// Optional TSTRB checking is enabled by defining DTW_S_AXIS_TSTRB_CHECK_EN.
module dtw_accel_s00_axis #(
    parameter int unsigned C_S_AXIS_TDATA_WIDTH = 32,
    parameter int unsigned FIFO_DEPTH           = 16,
    localparam int unsigned AddrW               = $clog2(FIFO_DEPTH),
    localparam int unsigned CntW                = AddrW + 1
) (
    input  logic                            S_AXIS_ACLK,
    input  logic                            S_AXIS_ARESETN,
    dtw_accel_s00_axis_if.slave             s_axis,
    input  logic                            dtw_fifo_rden,
    output logic [C_S_AXIS_TDATA_WIDTH-1:0] dtw_fifo_dout,
    output logic                            dtw_fifo_last,
    output logic                            dtw_fifo_empty,
    output logic [CntW-1:0]                 dtw_fifo_count,
    output logic                            pkt_busy,
    output logic [15:0]                     pkt_count,
    output logic [15:0]                     pkt_len,
    output logic                            strb_err
);
    localparam int unsigned W = C_S_AXIS_TDATA_WIDTH;

    typedef enum logic [0:0] {StIdle, StRecv} state_e;

    logic [W:0]       mem [FIFO_DEPTH];
    logic [AddrW-1:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
    logic [CntW-1:0]  count_q, count_d;
    logic [W-1:0]     dout_q, dout_d;
    logic             last_q, last_d;
    state_e           state_q, state_d;
    logic [15:0]      wcnt_q, wcnt_d, wcnt_inc;
    logic [15:0]      pkt_count_q, pkt_count_d;
    logic [15:0]      pkt_len_q, pkt_len_d;
    logic             strb_err_q, strb_err_d;
    logic             wr_en, rd_en;
    logic [W:0]       rd_word;

    // Ready comes from the registered count only, so no input reaches it combinationally.
    assign s_axis.tready = (count_q != CntW'(FIFO_DEPTH));
    assign wr_en         = s_axis.tvalid & s_axis.tready;
    assign rd_en         = dtw_fifo_rden & (count_q != '0);
    assign rd_word       = mem[rd_ptr_q];
    assign wcnt_inc      = (wcnt_q == 16'hFFFF) ? 16'hFFFF : wcnt_q + 16'd1;

    always_comb begin
        wr_ptr_d    = wr_en ? wr_ptr_q + 1'b1 : wr_ptr_q;
        rd_ptr_d    = rd_en ? rd_ptr_q + 1'b1 : rd_ptr_q;
        count_d     = count_q;
        dout_d      = dout_q;
        last_d      = last_q;
        state_d     = state_q;
        wcnt_d      = wcnt_q;
        pkt_count_d = pkt_count_q;
        pkt_len_d   = pkt_len_q;
        strb_err_d  = strb_err_q;

        if (wr_en && !rd_en) count_d = count_q + 1'b1;
        if (rd_en && !wr_en) count_d = count_q - 1'b1;
        if (rd_en) begin
            dout_d = rd_word[W-1:0];
            last_d = rd_word[W];
        end

        if (wr_en) begin
            if (s_axis.tlast) begin
                state_d     = StIdle;
                pkt_count_d = pkt_count_q + 16'd1;
                pkt_len_d   = (state_q == StRecv) ? wcnt_inc : 16'd1;
            end else if (state_q == StIdle) begin
                state_d = StRecv;
                wcnt_d  = 16'd1;
            end else begin
                wcnt_d = wcnt_inc;
            end
        end

`ifdef DTW_S_AXIS_TSTRB_CHECK_EN
        if (wr_en && (s_axis.tstrb != '1)) strb_err_d = 1'b1;
`endif
    end

    always_ff @(posedge S_AXIS_ACLK or negedge S_AXIS_ARESETN) begin
        if (!S_AXIS_ARESETN) begin
            wr_ptr_q    <= '0;
            rd_ptr_q    <= '0;
            count_q     <= '0;
            dout_q      <= '0;
            last_q      <= 1'b0;
            state_q     <= StIdle;
            wcnt_q      <= '0;
            pkt_count_q <= '0;
            pkt_len_q   <= '0;
            strb_err_q  <= 1'b0;
        end else begin
            wr_ptr_q    <= wr_ptr_d;
            rd_ptr_q    <= rd_ptr_d;
            count_q     <= count_d;
            dout_q      <= dout_d;
            last_q      <= last_d;
            state_q     <= state_d;
            wcnt_q      <= wcnt_d;
            pkt_count_q <= pkt_count_d;
            pkt_len_q   <= pkt_len_d;
            strb_err_q  <= strb_err_d;
        end
    end

    // Storage is not reset; stale words are unreachable once the pointers clear.
    always_ff @(posedge S_AXIS_ACLK) begin
        if (wr_en) mem[wr_ptr_q] <= {s_axis.tlast, s_axis.tdata};
    end

`ifndef DTW_S_AXIS_TSTRB_CHECK_EN
    logic unused_tstrb;
    assign unused_tstrb = ^s_axis.tstrb;
`endif

    assign dtw_fifo_dout  = dout_q;
    assign dtw_fifo_last  = last_q;
    assign dtw_fifo_empty = (count_q == '0);
    assign dtw_fifo_count = count_q;
    assign pkt_busy       = (state_q == StRecv);
    assign pkt_count      = pkt_count_q;
    assign pkt_len        = pkt_len_q;
    assign strb_err       = strb_err_q;
endmodule

// File: tb/tb_dtw_accel_s00_axis.sv
// Bench for dtw_accel_s00_axis: queue-based reference model compared every cycle plus directed checks.
module tb_dtw_accel_s00_axis;
    localparam int unsigned W     = 32;
    localparam int unsigned Depth = 16;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        rden = 1'b0;
    logic [W-1:0] dout;
    logic        last, empty, busy, serr;
    logic [4:0]  count;
    logic [15:0] pcount, plen;

    int checks = 0;
    int failures = 0;
    bit cmp_en = 1'b0;

    dtw_accel_s00_axis_if #(.DataWidth(W)) ifc ();

    dtw_accel_s00_axis #(.C_S_AXIS_TDATA_WIDTH(W), .FIFO_DEPTH(Depth)) dut (
        .S_AXIS_ACLK(clk),
        .S_AXIS_ARESETN(rst_n),
        .s_axis(ifc.slave),
        .dtw_fifo_rden(rden),
        .dtw_fifo_dout(dout),
        .dtw_fifo_last(last),
        .dtw_fifo_empty(empty),
        .dtw_fifo_count(count),
        .pkt_busy(busy),
        .pkt_count(pcount),
        .pkt_len(plen),
        .strb_err(serr)
    );

    always #5 clk = ~clk;

    // Reference model: a queue of {last, data} words and a running word count for the open packet.
    logic [W:0]   mq[$];
    logic [W-1:0] m_dout;
    logic         m_last;
    int           m_words;
    int           m_pcount;
    int           m_plen;
    bit           m_serr;

    task automatic model_reset();
        mq.delete();
        m_dout = '0; m_last = 1'b0; m_words = 0; m_pcount = 0; m_plen = 0; m_serr = 1'b0;
    endtask

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    always @(posedge clk) begin
        if (rst_n) begin
            bit wr, rd;
            logic [W:0] w;
            wr = ifc.tvalid && (mq.size() < Depth);
            rd = rden && (mq.size() > 0);
            if (rd) begin
                w = mq.pop_front();
                m_dout = w[W-1:0];
                m_last = w[W];
            end
            if (wr) begin
                mq.push_back({ifc.tlast, ifc.tdata});
                m_words++;
                if (ifc.tlast) begin
                    m_plen   = (m_words > 65535) ? 65535 : m_words;
                    m_pcount = (m_pcount + 1) % 65536;
                    m_words  = 0;
                end
`ifdef DTW_S_AXIS_TSTRB_CHECK_EN
                if (ifc.tstrb != 4'hF) m_serr = 1'b1;
`endif
            end
        end
    end

    always @(negedge clk) begin
        if (rst_n && cmp_en) begin
            check("tready", ifc.tready, mq.size() != Depth);
            check("count", count, mq.size());
            check("empty", empty, mq.size() == 0);
            check("dout", dout, m_dout);
            check("last", last, m_last);
            check("pkt_busy", busy, m_words > 0);
            check("pkt_count", pcount, m_pcount);
            check("pkt_len", plen, m_plen);
            check("strb_err", serr, m_serr);
        end
    end

    task automatic send(input logic [W-1:0] d, input logic l, input logic [3:0] s);
        int n = 0;
        ifc.tvalid = 1'b1; ifc.tdata = d; ifc.tlast = l; ifc.tstrb = s;
        while (!ifc.tready && n < 50) begin
            @(negedge clk);
            n++;
        end
        if (n >= 50) check("send_timeout", 1, 0);
        @(negedge clk);
        ifc.tvalid = 1'b0;
    endtask

    task automatic drain();
        int n = 0;
        rden = 1'b1;
        while (mq.size() > 0 && n < 50) begin
            @(negedge clk);
            n++;
        end
        rden = 1'b0;
        if (n >= 50) check("drain_timeout", 1, 0);
    endtask

    logic [W-1:0] exp_d[4];
    logic         exp_l[4];

    initial begin
        exp_d[0] = 32'h11; exp_d[1] = 32'h22; exp_d[2] = 32'h33; exp_d[3] = 32'h44;
        exp_l[0] = 1'b0; exp_l[1] = 1'b0; exp_l[2] = 1'b0; exp_l[3] = 1'b1;
        ifc.tvalid = 1'b0; ifc.tdata = '0; ifc.tlast = 1'b0; ifc.tstrb = 4'hF;
        model_reset();
        repeat (2) @(negedge clk);
        check("rst_tready", ifc.tready, 1);
        check("rst_empty", empty, 1);
        check("rst_count", count, 0);
        check("rst_dout", dout, 0);
        check("rst_pkt_count", pcount, 0);
        check("rst_strb_err", serr, 0);
        rst_n = 1'b1;
        cmp_en = 1'b1;
        @(negedge clk);

        // Four-beat packet, then read it back one word per cycle.
        for (int i = 0; i < 4; i++) send(exp_d[i], exp_l[i], 4'hF);
        check("t1_pkt_len", plen, 4);
        check("t1_pkt_count", pcount, 1);
        rden = 1'b1;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            check("t1_dout", dout, exp_d[i]);
            check("t1_last", last, exp_l[i]);
        end
        rden = 1'b0;
        check("t1_empty", empty, 1);

        // Fill to full, hold off a 17th beat, then free one slot.
        for (int i = 0; i < 16; i++) send(32'h100 + i, i == 15, 4'hF);
        check("t2_tready_full", ifc.tready, 0);
        check("t2_count_full", count, 16);
        ifc.tvalid = 1'b1; ifc.tdata = 32'h99; ifc.tlast = 1'b1;
        repeat (2) @(negedge clk);
        check("t2_held_off", count, 16);
        rden = 1'b1;
        @(negedge clk);
        rden = 1'b0;
        check("t2_tready_back", ifc.tready, 1);
        check("t2_first_out", dout, 32'h100);
        @(negedge clk);
        ifc.tvalid = 1'b0;
        check("t2_refill", count, 16);
        drain();
        check("t2_last_out", dout, 32'h99);

        // Reads on an empty FIFO, then a write racing a read while empty.
        rden = 1'b1;
        repeat (3) @(negedge clk);
        check("t3_dout_hold", dout, 32'h99);
        check("t3_count0", count, 0);
        ifc.tvalid = 1'b1; ifc.tdata = 32'hAB; ifc.tlast = 1'b1;
        @(negedge clk);
        ifc.tvalid = 1'b0; rden = 1'b0;
        check("t3_count1", count, 1);
        check("t3_dout_same", dout, 32'h99);
        drain();
        check("t3_dout_ab", dout, 32'hAB);

        // Single-beat packets.
        for (int i = 0; i < 3; i++) send(32'h200 + i, 1'b1, 4'hF);
        check("t4_pkt_count", pcount, 7);
        check("t4_pkt_len", plen, 1);
        check("t4_busy", busy, 0);
        drain();

        // Asynchronous reset in the middle of a packet.
        for (int i = 0; i < 3; i++) send(32'h300 + i, 1'b0, 4'hF);
        check("t5_busy_before", busy, 1);
        #2 rst_n = 1'b0;
        #1;
        check("t5_tready", ifc.tready, 1);
        check("t5_count", count, 0);
        check("t5_busy", busy, 0);
        check("t5_pkt_count", pcount, 0);
        check("t5_empty", empty, 1);
        model_reset();
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);

        // TSTRB checking.
        send(32'h400, 1'b0, 4'b0111);
        for (int i = 0; i < 10; i++) send(32'h401 + i, i == 9, 4'hF);
`ifdef DTW_S_AXIS_TSTRB_CHECK_EN
        check("t6_strb_err", serr, 1);
`else
        check("t6_strb_err", serr, 0);
`endif
        check("t6_pkt_len", plen, 11);
        drain();
        @(negedge clk);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
